// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - CPU/debug arbiter for the banked data memory.
// Define DATA_MEMORY_ARB_ROUND_ROBIN_EN to replace the streak guard with round-robin on ties.
module data_memory_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int BANK_WIDTH   = 2,
  parameter int READ_LATENCY = 1,
  parameter int MAX_STREAK   = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_cpu_req,
  input  logic                             in_cpu_we,
  input  logic [BANK_WIDTH-1:0]            in_cpu_bank,
  input  logic [ADDR_WIDTH-1:0]            in_cpu_addr,
  input  logic [DATA_WIDTH-1:0]            in_cpu_wdata,
  output logic                             out_cpu_gnt,
  output logic                             out_cpu_done,
  input  logic                             in_dbg_req,
  input  logic                             in_dbg_we,
  input  logic [BANK_WIDTH-1:0]            in_dbg_bank,
  input  logic [ADDR_WIDTH-1:0]            in_dbg_addr,
  input  logic [DATA_WIDTH-1:0]            in_dbg_wdata,
  output logic                             out_dbg_gnt,
  output logic                             out_dbg_done,
  output logic [DATA_WIDTH-1:0]            out_rdata,
  output logic                             out_busy,
  output logic [BANK_WIDTH+ADDR_WIDTH-1:0] out_mem_addr,
  output logic [DATA_WIDTH-1:0]            out_mem_wdata,
  output logic                             out_mem_wr_en,
  output logic                             out_mem_rd_en,
  input  logic [DATA_WIDTH-1:0]            in_mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT_RD, RESP} state_t;

  state_t     state;
  logic [2:0] wait_cnt;
  logic       cpu_wins;

`ifdef DATA_MEMORY_ARB_ROUND_ROBIN_EN
  logic last_dbg;

  always_comb cpu_wins = in_cpu_req && (!in_dbg_req || last_dbg);
`else
  logic [3:0] streak;

  // CPU keeps priority until it has starved a pending debug request MAX_STREAK times.
  always_comb cpu_wins = in_cpu_req && !(in_dbg_req && (streak == MAX_STREAK[3:0]));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= 3'd0;
      out_cpu_gnt   <= 1'b0;
      out_cpu_done  <= 1'b0;
      out_dbg_gnt   <= 1'b0;
      out_dbg_done  <= 1'b0;
      out_rdata     <= '0;
      out_busy      <= 1'b0;
      out_mem_addr  <= '0;
      out_mem_wdata <= '0;
      out_mem_wr_en <= 1'b0;
      out_mem_rd_en <= 1'b0;
`ifdef DATA_MEMORY_ARB_ROUND_ROBIN_EN
      last_dbg      <= 1'b1;
`else
      streak        <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_cpu_req || in_dbg_req) begin
            state       <= ACCESS;
            out_busy    <= 1'b1;
            out_cpu_gnt <= cpu_wins;
            out_dbg_gnt <= !cpu_wins;
            if (cpu_wins) begin
              out_mem_addr  <= {in_cpu_bank, in_cpu_addr};
              out_mem_wdata <= in_cpu_wdata;
              out_mem_wr_en <= in_cpu_we;
              out_mem_rd_en <= !in_cpu_we;
            end else begin
              out_mem_addr  <= {in_dbg_bank, in_dbg_addr};
              out_mem_wdata <= in_dbg_wdata;
              out_mem_wr_en <= in_dbg_we;
              out_mem_rd_en <= !in_dbg_we;
            end
`ifdef DATA_MEMORY_ARB_ROUND_ROBIN_EN
            last_dbg <= !cpu_wins;
`endif
          end
`ifndef DATA_MEMORY_ARB_ROUND_ROBIN_EN
          if (!in_dbg_req || !cpu_wins) begin
            streak <= 4'd0;
          end else if (streak != MAX_STREAK[3:0]) begin
            streak <= streak + 4'd1;
          end
`endif
        end
        ACCESS: begin
          out_mem_wr_en <= 1'b0;
          out_mem_rd_en <= 1'b0;
          if (out_mem_wr_en) begin
            state        <= RESP;
            out_cpu_done <= out_cpu_gnt;
            out_dbg_done <= out_dbg_gnt;
          end else begin
            state    <= WAIT_RD;
            wait_cnt <= READ_LATENCY[2:0];
          end
        end
        WAIT_RD: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt == 3'd1) begin
            out_rdata    <= in_mem_rdata;
            state        <= RESP;
            out_cpu_done <= out_cpu_gnt;
            out_dbg_done <= out_dbg_gnt;
          end
        end
        RESP: begin
          state        <= IDLE;
          out_busy     <= 1'b0;
          out_cpu_gnt  <= 1'b0;
          out_dbg_gnt  <= 1'b0;
          out_cpu_done <= 1'b0;
          out_dbg_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
